// File: rtl/huff_sym_histogram.sv
// Symbol-frequency histogram for the Huffman datapath: counts TOTAL samples into
// one {count, flag} entry per symbol, then holds the bank for PE write-back.
module huff_sym_histogram #(
  parameter int NUM_SYM = 6,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TOTAL   = 100,
  localparam int FLAG_W = NUM_SYM + 1,
  localparam int EW     = CNT_W + FLAG_W,
  localparam int TW     = $clog2(TOTAL + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  load_en,
  input  logic [NUM_SYM*EW-1:0] load_bus,
  output logic [NUM_SYM*EW-1:0] cnt_bus,
  output logic [TW-1:0]         total,
  output logic [NUM_SYM-1:0]    sat,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, COUNT, FLUSH, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TW-1:0]    LAST_IDX = TW'(TOTAL - 1);

  state_t              state_q, state_d;
  logic [EW-1:0]       ent_q [NUM_SYM];
  logic [EW-1:0]       ent_d [NUM_SYM];
  logic [TW-1:0]       total_q, total_d;
  logic [NUM_SYM-1:0]  sat_q, sat_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;

  // Live marker at the top flag bit plus a one-hot symbol identity below it.
  function automatic logic [EW-1:0] init_entry(input int k);
    logic [FLAG_W-1:0] flag;
    flag = (FLAG_W'(1) << NUM_SYM) | (FLAG_W'(1) << (NUM_SYM - k));
    return {{CNT_W{1'b0}}, flag};
  endfunction

  function automatic logic is_max(input logic [CNT_W-1:0] c);
    return c == CNT_MAX;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return is_max(c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    data_d  = data_q;
    ent_d   = ent_q;

    if (start) begin
      state_d = COUNT;
      total_d = '0;
      sat_d   = '0;
      data_d  = '0;
      for (int k = 0; k < NUM_SYM; k++) ent_d[k] = init_entry(k + 1);
    end else begin
      // Increment stage: out-of-range codes match no entry and fall through.
      for (int k = 0; k < NUM_SYM; k++) begin
        if (valid_q && (data_q == DATA_W'(k + 1))) begin
          if (is_max(ent_q[k][EW-1 -: CNT_W])) sat_d[k] = 1'b1;
          ent_d[k][EW-1 -: CNT_W] = sat_inc(ent_q[k][EW-1 -: CNT_W]);
        end
      end

      unique case (state_q)
        COUNT: begin
          if (in_valid) begin
            valid_d = 1'b1;
            data_d  = in_data;
            total_d = total_q + 1'b1;
            if (total_q == LAST_IDX) state_d = FLUSH;
          end
        end
        FLUSH: begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
        HOLD: begin
          if (load_en) begin
            for (int k = 0; k < NUM_SYM; k++) ent_d[k] = load_bus[k*EW +: EW];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      total_q <= '0;
      sat_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int k = 0; k < NUM_SYM; k++) ent_q[k] <= init_entry(k + 1);
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ent_q   <= ent_d;
    end
  end

  for (genvar g = 0; g < NUM_SYM; g++) begin : g_pack
    assign cnt_bus[g*EW +: EW] = ent_q[g];
  end

  assign in_ready = (state_q == COUNT);
  assign busy     = (state_q == COUNT) || (state_q == FLUSH);
  assign done     = done_q;
  assign total    = total_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_huff_sym_histogram.sv
// Bench for huff_sym_histogram: timing-based behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_huff_sym_histogram;

  localparam int NS  = 6;
  localparam int TOT = 100;
  localparam int EW  = 15;
  localparam int SEW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, in_valid, load_en;
  logic [7:0]    in_data;
  logic [89:0]   load_bus;
  logic          in_ready, busy, done;
  logic [89:0]   cnt_bus;
  logic [6:0]    total;
  logic [5:0]    sat;

  logic          s_start, s_in_valid, s_load_en;
  logic [7:0]    s_in_data;
  logic [65:0]   s_load_bus;
  logic          s_in_ready, s_busy, s_done;
  logic [65:0]   s_cnt_bus;
  logic [4:0]    s_total;
  logic [5:0]    s_sat;

  huff_sym_histogram #(.NUM_SYM(6), .DATA_W(8), .CNT_W(8), .TOTAL(100)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_en(load_en), .load_bus(load_bus), .cnt_bus(cnt_bus),
    .total(total), .sat(sat), .busy(busy), .done(done)
  );

  huff_sym_histogram #(.NUM_SYM(6), .DATA_W(8), .CNT_W(4), .TOTAL(20)) u_sat (
    .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .load_en(s_load_en), .load_bus(s_load_bus), .cnt_bus(s_cnt_bus),
    .total(s_total), .sat(s_sat), .busy(s_busy), .done(s_done)
  );

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] init_flag(input int k);
    return 7'(1 << NS) | 7'(1 << (NS - k));
  endfunction

  function automatic logic [7:0] cnt_of(input logic [89:0] b, input int k);
    return b[(k-1)*EW + 7 +: 8];
  endfunction

  function automatic logic [14:0] ent_of(input logic [89:0] b, input int k);
    return b[(k-1)*EW +: EW];
  endfunction

  // Model: histogram as plain arrays; FSM behaviour expressed through edge timestamps.
  int         ecount = 0;
  int         m_acc = 0;
  int         end_edge = -1;
  int         pend_edge = -1;
  int         pend_code = 0;
  bit         accepting = 1'b0;
  int         m_cnt [NS];
  logic [6:0] m_flag [NS];
  logic [5:0] m_sat = '0;

  task automatic m_init();
    for (int k = 0; k < NS; k++) begin
      m_cnt[k]  = 0;
      m_flag[k] = init_flag(k + 1);
    end
    m_sat     = '0;
    m_acc     = 0;
    pend_edge = -1;
    end_edge  = -1;
  endtask

  function automatic logic [89:0] model_bus();
    logic [89:0] b;
    b = '0;
    for (int k = 0; k < NS; k++) b[k*EW +: EW] = {8'(m_cnt[k]), m_flag[k]};
    return b;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_init();
      accepting = 1'b0;
    end else begin
      ecount++;
      if (start) begin
        m_init();
        accepting = 1'b1;
      end else begin
        if (pend_edge == ecount) begin
          if (pend_code >= 1 && pend_code <= NS) begin
            if (m_cnt[pend_code-1] == 255) m_sat[pend_code-1] = 1'b1;
            else m_cnt[pend_code-1]++;
          end
          pend_edge = -1;
        end
        if (end_edge >= 0 && ecount >= end_edge + 2 && load_en) begin
          for (int k = 0; k < NS; k++) begin
            m_cnt[k]  = int'(load_bus[k*EW + 7 +: 8]);
            m_flag[k] = load_bus[k*EW +: 7];
          end
        end
        if (accepting && in_valid) begin
          m_acc++;
          pend_code = int'(in_data);
          pend_edge = ecount + 1;
          if (m_acc == TOT) begin
            accepting = 1'b0;
            end_edge  = ecount;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc cnt_bus", 128'(cnt_bus), 128'(model_bus()));
      check("cyc total", 128'(total), 128'(m_acc));
      check("cyc sat", 128'(sat), 128'(m_sat));
      check("cyc in_ready", 128'(in_ready), 128'(accepting));
      check("cyc busy", 128'(busy), 128'(accepting || (end_edge >= 0 && ecount == end_edge)));
      check("cyc done", 128'(done), 128'(end_edge >= 0 && ecount == end_edge + 1));
      if (done) done_seen++;
    end
  end

  task automatic sample(input logic [7:0] code);
    in_valid = 1'b1;
    in_data  = code;
    @(negedge clk);
  endtask

  task automatic begin_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [89:0] snap;
  int          d0;

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; load_en = 1'b0; load_bus = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_load_en = 1'b0; s_load_bus = '0;
    repeat (2) @(negedge clk);
    check("reset total", 128'(total), 128'(0));
    check("reset sat", 128'(sat), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset in_ready", 128'(in_ready), 128'(0));
    check("reset entry1", 128'(ent_of(cnt_bus, 1)), 128'({8'd0, 7'b1100000}));
    check("reset entry6", 128'(ent_of(cnt_bus, 6)), 128'({8'd0, 7'b1000001}));
    chk_en = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);

    // Frame of 100 samples cycling 1..6
    begin_frame();
    for (int i = 0; i < TOT; i++) begin
      if (i == TOT - 1) check("ready before last", 128'(in_ready), 128'(1));
      sample(8'((i % 6) + 1));
    end
    in_valid = 1'b0;
    check("ready after last", 128'(in_ready), 128'(0));
    check("flush busy", 128'(busy), 128'(1));
    @(negedge clk);
    check("frame1 done", 128'(done), 128'(1));
    check("frame1 total", 128'(total), 128'(100));
    for (int k = 1; k <= 4; k++) check($sformatf("frame1 cnt%0d", k), 128'(cnt_of(cnt_bus, k)), 128'(17));
    for (int k = 5; k <= 6; k++) check($sformatf("frame1 cnt%0d", k), 128'(cnt_of(cnt_bus, k)), 128'(16));
    check("frame1 flag1", 128'(ent_of(cnt_bus, 1)), 128'({8'd17, 7'b1100000}));
    snap = cnt_bus;
    @(negedge clk);
    check("frame1 done low", 128'(done), 128'(0));
    check("frame1 one pulse", 128'(done_seen), 128'(1));
    check("frame1 stable", 128'(cnt_bus), 128'(snap));

    // PE write-back in HOLD
    for (int k = 1; k <= NS; k++) load_bus[(k-1)*EW +: EW] = {8'(k * 10), init_flag(k)};
    load_bus[0 +: EW] = {8'd33, 7'b1110000};
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check("load entry1", 128'(ent_of(cnt_bus, 1)), 128'({8'd33, 7'b1110000}));
    check("load cnt4", 128'(cnt_of(cnt_bus, 4)), 128'(40));

    // Single sample latency, then load_en during COUNT is ignored
    begin_frame();
    sample(8'd3);
    in_valid = 1'b0;
    load_en  = 1'b1;
    check("lat t+1", 128'(cnt_of(cnt_bus, 3)), 128'(0));
    @(negedge clk);
    check("lat t+2", 128'(cnt_of(cnt_bus, 3)), 128'(1));
    check("count load ignored", 128'(ent_of(cnt_bus, 1)), 128'({8'd0, 7'b1100000}));
    for (int i = 0; i < TOT - 1; i++) sample(8'd5);
    in_valid = 1'b0;
    load_en  = 1'b0;
    @(negedge clk);
    check("f2 cnt5", 128'(cnt_of(cnt_bus, 5)), 128'(99));
    check("f2 cnt3", 128'(cnt_of(cnt_bus, 3)), 128'(1));
    check("f2 total", 128'(total), 128'(100));

    // Out-of-range codes 0 and 9 interleaved with code 1
    begin_frame();
    for (int i = 0; i < TOT; i++) begin
      if (i % 2 == 0) sample(8'd1);
      else if (i % 4 == 1) sample(8'd0);
      else sample(8'd9);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("oor cnt1", 128'(cnt_of(cnt_bus, 1)), 128'(50));
    for (int k = 2; k <= NS; k++) check($sformatf("oor cnt%0d", k), 128'(cnt_of(cnt_bus, k)), 128'(0));
    check("oor total", 128'(total), 128'(100));

    // start during FLUSH: no done pulse, pending sample dropped
    begin_frame();
    for (int i = 0; i < TOT; i++) sample(8'd6);
    in_valid = 1'b0;
    d0 = done_seen;
    begin_frame();
    check("flush-start ready", 128'(in_ready), 128'(1));
    check("flush-start cnt6", 128'(cnt_of(cnt_bus, 6)), 128'(0));
    check("flush-start total", 128'(total), 128'(0));
    @(negedge clk);
    check("flush-start no done", 128'(done_seen), 128'(d0));

    // Reset mid-frame at total=40
    for (int i = 0; i < 40; i++) sample(8'd2);
    in_valid = 1'b0;
    check("mid total", 128'(total), 128'(40));
    #2 reset = 1'b0;
    #1;
    check("async entry2", 128'(ent_of(cnt_bus, 2)), 128'({8'd0, 7'b1010000}));
    check("async total", 128'(total), 128'(0));
    check("async busy", 128'(busy), 128'(0));
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) sample(8'd1);
    in_valid = 1'b0;
    check("idle ignore total", 128'(total), 128'(0));
    check("idle ignore cnt1", 128'(cnt_of(cnt_bus, 1)), 128'(0));
    check("idle ready", 128'(in_ready), 128'(0));

    // Saturation with CNT_W=4, TOTAL=20
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'd2;
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    check("sat done", 128'(s_done), 128'(1));
    check("sat cnt2", 128'(s_cnt_bus[SEW + 7 +: 4]), 128'(15));
    check("sat flags", 128'(s_sat), 128'(6'b000010));
    check("sat total", 128'(s_total), 128'(20));
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("sat clr cnt2", 128'(s_cnt_bus[SEW + 7 +: 4]), 128'(0));
    check("sat clr flags", 128'(s_sat), 128'(0));

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
